// File: rtl/operand_resolver_pkg.sv
// rtl/operand_resolver_pkg.sv - register numbers, addressing modes, formats and FSM states for operand_resolver
package operand_resolver_pkg;

  localparam logic [3:0] REG_PC  = 4'd0;
  localparam logic [3:0] REG_SP  = 4'd1;
  localparam logic [3:0] REG_CG1 = 4'd2;
  localparam logic [3:0] REG_CG2 = 4'd3;

  typedef enum logic [1:0] {
    AM_REGISTER              = 2'b00,
    AM_INDEXED               = 2'b01,
    AM_INDIRECT              = 2'b10,
    AM_INDIRECT_AUTOINCREMENT = 2'b11
  } addrMode_e;

  typedef enum logic [1:0] {
    FMT_NONE      = 2'd0,
    FMT_TWO_OP    = 2'd1,
    FMT_SINGLE_OP = 2'd2,
    FMT_JUMP      = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SRC_EXT = 2'd1,
    ST_DST_EXT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic fmt_e decodeFormat(input logic [15:0] w);
    if (w[15:14] != 2'b00) return FMT_TWO_OP;
    if (w[15:10] == 6'b000100) return FMT_SINGLE_OP;
    if (w[15:13] == 3'b001) return FMT_JUMP;
    return FMT_NONE;
  endfunction

endpackage

// File: rtl/operand_resolver_cg_const_decode.sv
// rtl/operand_resolver_cg_const_decode.sv - combinational CG1/CG2 constant and extension-need decode
module cg_const_decode
  import operand_resolver_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        srcA,
  input  addrMode_e         as,
  input  logic [3:0]        dstA,
  input  logic              ad,
  input  logic              bw,
  input  fmt_e              fmt,
  output logic [DATA_W-1:0] srcConst,
  output logic              srcGen,
  output logic              dstGen,
  output logic              srcExt,
  output logic              dstExt
);

  always_comb begin
    srcConst = '0;
    srcGen   = 1'b0;
    srcExt   = 1'b0;
    dstGen   = 1'b0;
    dstExt   = 1'b0;
    if (fmt == FMT_TWO_OP || fmt == FMT_SINGLE_OP) begin
      // R2 indexed is absolute addressing: generator supplies base 0, word still fetched
      if (srcA == REG_CG1) begin
        unique case (as)
          AM_INDEXED:                srcGen = 1'b1;
          AM_INDIRECT:               begin srcGen = 1'b1; srcConst = DATA_W'(4); end
          AM_INDIRECT_AUTOINCREMENT: begin srcGen = 1'b1; srcConst = DATA_W'(8); end
          default:                   srcGen = 1'b0;
        endcase
      end else if (srcA == REG_CG2) begin
        srcGen = 1'b1;
        unique case (as)
          AM_REGISTER:               srcConst = DATA_W'(0);
          AM_INDEXED:                srcConst = DATA_W'(1);
          AM_INDIRECT:               srcConst = DATA_W'(2);
          AM_INDIRECT_AUTOINCREMENT: srcConst = bw ? DATA_W'(8'hFF) : '1;
        endcase
      end
      srcExt = (as == AM_INDEXED && srcA != REG_CG2) ||
               (as == AM_INDIRECT_AUTOINCREMENT && srcA == REG_PC);
    end
    if (fmt == FMT_TWO_OP) begin
      dstGen = (dstA == REG_CG1 && ad) || (dstA == REG_CG2 && !ad);
      dstExt = ad && (dstA != REG_CG2);
    end
  end

endmodule

// File: rtl/operand_resolver.sv
// rtl/operand_resolver.sv - operand bundle sequencer with extension-word fetch
// Optional statistics counters: OPERAND_RESOLVER_STATS_EN
module operand_resolver
  import operand_resolver_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       iw,
  output logic              ext_req,
  input  logic              ext_ack,
  input  logic [15:0]       ext_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src_val,
  output logic [15:0]       dst_ext_val,
  output logic              src_gen,
  output logic              dst_gen,
  output logic [1:0]        ext_count,
  output logic [15:0]       cg_hits,
  output logic [15:0]       ext_fetches
);

  state_e            state;
  fmt_e              fmt;
  logic [3:0]        srcReg;
  logic [DATA_W-1:0] srcConst;
  logic              srcGen, dstGen, srcExt, dstExt;
  logic              dstExtPending;

  assign fmt    = decodeFormat(iw);
  assign srcReg = (fmt == FMT_TWO_OP) ? iw[11:8] : iw[3:0];

  cg_const_decode #(.DATA_W(DATA_W)) uDecode (
    .srcA     (srcReg),
    .as       (addrMode_e'(iw[5:4])),
    .dstA     (iw[3:0]),
    .ad       (iw[7]),
    .bw       (iw[6]),
    .fmt      (fmt),
    .srcConst (srcConst),
    .srcGen   (srcGen),
    .dstGen   (dstGen),
    .srcExt   (srcExt),
    .dstExt   (dstExt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      ext_req       <= 1'b0;
      out_valid     <= 1'b0;
      src_val       <= '0;
      dst_ext_val   <= '0;
      src_gen       <= 1'b0;
      dst_gen       <= 1'b0;
      ext_count     <= '0;
      dstExtPending <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      ext_req   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) begin
          src_val       <= srcConst;
          src_gen       <= srcGen;
          dst_gen       <= dstGen;
          dst_ext_val   <= '0;
          ext_count     <= '0;
          dstExtPending <= dstExt;
          in_ready      <= 1'b0;
          if (srcExt) begin
            state   <= ST_SRC_EXT;
            ext_req <= 1'b1;
          end else if (dstExt) begin
            state   <= ST_DST_EXT;
            ext_req <= 1'b1;
          end else begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_SRC_EXT: if (ext_ack) begin
          src_val   <= DATA_W'(ext_word);
          ext_count <= ext_count + 2'd1;
          if (dstExtPending) begin
            state <= ST_DST_EXT;
          end else begin
            state     <= ST_DONE;
            ext_req   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_DST_EXT: if (ext_ack) begin
          dst_ext_val <= ext_word;
          ext_count   <= ext_count + 2'd1;
          state       <= ST_DONE;
          ext_req     <= 1'b0;
          out_valid   <= 1'b1;
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef OPERAND_RESOLVER_STATS_EN
  logic [15:0] cgHitsQ, extFetchesQ;
  logic        bundleTaken, wordTaken;

  assign bundleTaken = (state == ST_DONE) && out_ready && !flush && (src_gen || dst_gen);
  assign wordTaken   = (state == ST_SRC_EXT || state == ST_DST_EXT) && ext_ack && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cgHitsQ     <= '0;
      extFetchesQ <= '0;
    end else begin
      if (bundleTaken && cgHitsQ != 16'hFFFF) cgHitsQ <= cgHitsQ + 16'd1;
      if (wordTaken && extFetchesQ != 16'hFFFF) extFetchesQ <= extFetchesQ + 16'd1;
    end
  end

  assign cg_hits     = cgHitsQ;
  assign ext_fetches = extFetchesQ;
`else
  assign cg_hits     = '0;
  assign ext_fetches = '0;
`endif

endmodule

// File: tb/tb_operand_resolver.sv
// tb/tb_operand_resolver.sv - self-checking bench for operand_resolver at DATA_W 16 and 20
module tb_operand_resolver;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, ext_ack, out_ready;
  logic [15:0] iw, ext_word;

  logic        in_ready, ext_req, out_valid, src_gen, dst_gen;
  logic [15:0] src_val, dst_ext_val, cg_hits, ext_fetches;
  logic [1:0]  ext_count;

  logic        in_readyW, ext_reqW, out_validW, src_genW, dst_genW;
  logic [19:0] src_valW;
  logic [15:0] dst_ext_valW, cg_hitsW, ext_fetchesW;
  logic [1:0]  ext_countW;

  int checks = 0;
  int errors = 0;
  int modelCg = 0;
  int modelExt = 0;

  always #5 clk = ~clk;

  operand_resolver #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .iw(iw), .ext_req(ext_req), .ext_ack(ext_ack), .ext_word(ext_word),
    .out_valid(out_valid), .out_ready(out_ready), .src_val(src_val),
    .dst_ext_val(dst_ext_val), .src_gen(src_gen), .dst_gen(dst_gen),
    .ext_count(ext_count), .cg_hits(cg_hits), .ext_fetches(ext_fetches)
  );

  operand_resolver #(.DATA_W(20)) dutW (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_readyW),
    .iw(iw), .ext_req(ext_reqW), .ext_ack(ext_ack), .ext_word(ext_word),
    .out_valid(out_validW), .out_ready(out_ready), .src_val(src_valW),
    .dst_ext_val(dst_ext_valW), .src_gen(src_genW), .dst_gen(dst_genW),
    .ext_count(ext_countW), .cg_hits(cg_hitsW), .ext_fetches(ext_fetchesW)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operand rules stated directly as lookups on register/mode
  function automatic void model(input logic [15:0] w, input int width, output logic [31:0] sv,
                                output bit sg, output bit dg, output bit se, output bit de);
    bit two, one;
    int s, am, d;
    two = (w[15:14] != 2'b00);
    one = !two && (w[15:10] == 6'b000100);
    s   = two ? int'(w[11:8]) : int'(w[3:0]);
    am  = int'(w[5:4]);
    d   = int'(w[3:0]);
    sv = 0; sg = 0; dg = 0; se = 0; de = 0;
    if (two || one) begin
      if (s == 3) begin
        sg = 1;
        if (am == 3) sv = w[6] ? 32'hFF : (width == 20 ? 32'hFFFFF : 32'hFFFF);
        else         sv = am;
      end else if (s == 2 && am != 0) begin
        sg = 1;
        sv = (am == 1) ? 0 : (am == 2 ? 4 : 8);
      end
      se = (am == 1 && s != 3) || (am == 3 && s == 0);
    end
    if (two) begin
      dg = (d == 2 && w[7]) || (d == 3 && !w[7]);
      de = w[7] && d != 3;
    end
  endfunction

  task automatic chkBundle(input string tag, input logic [31:0] sv16, input logic [31:0] sv20,
                           input bit sg, input bit dg, input logic [15:0] dv, input int n);
    chk({tag, "_valid"}, {out_valid, out_validW}, 2'b11);
    chk({tag, "_src16"}, src_val, sv16);
    chk({tag, "_src20"}, src_valW, sv20);
    chk({tag, "_gen"}, {src_gen, dst_gen, src_genW, dst_genW}, {sg, dg, sg, dg});
    chk({tag, "_dst"}, {dst_ext_val, dst_ext_valW}, {dv, dv});
    chk({tag, "_cnt"}, {ext_count, ext_countW}, {2'(n), 2'(n)});
    chk({tag, "_rdy_req"}, {in_ready, in_readyW, ext_req, ext_reqW}, 4'b0000);
  endtask

  task automatic runInstr(input string tag, input logic [15:0] w, input int dly, input int stall);
    logic [31:0] sv16, sv20;
    logic [15:0] words[2];
    logic [15:0] dv;
    bit sg, dg, se, de, sgW, dgW, seW, deW;
    int need, n, wt, cyc;
    model(w, 16, sv16, sg, dg, se, de);
    model(w, 20, sv20, sgW, dgW, seW, deW);
    words[0] = 16'($urandom);
    words[1] = 16'($urandom);
    need = int'(se) + int'(de);
    if (se) begin
      sv16 = {16'h0, words[0]};
      sv20 = {16'h0, words[0]};
    end
    dv = de ? words[se ? 1 : 0] : 16'h0;
    chk({tag, "_in_ready"}, {in_ready, in_readyW}, 2'b11);
    iw = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    iw = 16'($urandom);
    n = 0; wt = 0; cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (ext_req && wt == dly) begin
        ext_ack = 1'b1;
        ext_word = words[n];
        n++;
        wt = 0;
      end else begin
        ext_ack = 1'b0;
        ext_word = 16'($urandom);
        if (ext_req) wt++;
      end
      tick();
      ext_ack = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, need * (dly + 1));
    chk({tag, "_acks"}, n, need);
    chkBundle(tag, sv16, sv20, sg, dg, dv, need);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      iw = 16'h4335;
      ext_ack = 1'b1;
      ext_word = 16'($urandom);
      out_ready = 1'b0;
      tick();
      chkBundle({tag, "_stall"}, sv16, sv20, sg, dg, dv, need);
    end
    in_valid = 1'b0;
    ext_ack = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, {out_valid, out_validW, in_ready, in_readyW}, 4'b0011);
    modelCg += int'(sg || dg);
    modelExt += need;
  endtask

  task automatic chkStats(input string tag);
`ifdef OPERAND_RESOLVER_STATS_EN
    chk({tag, "_cg_hits"}, {cg_hits, cg_hitsW}, {16'(modelCg), 16'(modelCg)});
    chk({tag, "_ext_fetches"}, {ext_fetches, ext_fetchesW}, {16'(modelExt), 16'(modelExt)});
`else
    chk({tag, "_cg_hits"}, {cg_hits, cg_hitsW}, 32'h0);
    chk({tag, "_ext_fetches"}, {ext_fetches, ext_fetchesW}, 32'h0);
`endif
  endtask

  initial begin
    logic [15:0] w;
    int kind;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ext_ack = 1'b0; out_ready = 1'b0;
    iw = 16'h0; ext_word = 16'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ctl", {in_ready, in_readyW, ext_req, ext_reqW, out_valid, out_validW}, 6'b110000);
    chk("reset_data", {src_val, dst_ext_val, src_gen, dst_gen, ext_count}, 36'h0);
    chk("reset_dataW", {src_valW, dst_ext_valW, src_genW, dst_genW, ext_countW}, 40'h0);
    chkStats("reset");

    runInstr("mov_m1", 16'h4335, 0, 0);
    runInstr("movb_m1", 16'h4375, 0, 0);
    runInstr("mov_imm_abs", 16'h40B2, 2, 0);
    runInstr("jmp", 16'h3C00, 0, 0);
    runInstr("stall", 16'h4335, 0, 3);
    chkStats("directed");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      w = 16'($urandom);
      if (kind <= 1) begin
        w[15:14] = 2'($urandom_range(1, 3));
        if (kind == 0) w[11:8] = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) w[3:0] = 4'($urandom_range(2, 3));
      end else if (kind == 2) begin
        w[15:10] = 6'b000100;
        w[3:0] = 4'($urandom_range(0, 3));
      end else begin
        w[15:13] = 3'b001;
      end
      runInstr($sformatf("rand%0d_%h", i, w), w, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    chkStats("random");

    // flush while waiting for the source extension, colliding with an ack
    iw = 16'h40B2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush_pre_req", {ext_req, ext_reqW}, 2'b11);
    flush = 1'b1;
    ext_ack = 1'b1;
    ext_word = 16'hBEEF;
    tick();
    flush = 1'b0;
    ext_ack = 1'b0;
    chk("flush_idle", {in_ready, ext_req, out_valid, in_readyW, ext_reqW, out_validW}, 6'b100100);
    tick();
    tick();
    chk("flush_no_bundle", {out_valid, out_validW, ext_req}, 3'b000);
    chkStats("flush");
    runInstr("after_flush", 16'h4375, 1, 1);

    // asynchronous reset while waiting for the destination extension
    iw = 16'h40B2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ext_ack = 1'b1;
    ext_word = 16'h1234;
    tick();
    ext_ack = 1'b0;
    chk("rst_pre_state", {ext_req, src_val, ext_count}, {1'b1, 16'h1234, 2'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", {ext_req, out_valid, src_val, dst_ext_val, src_gen, dst_gen, ext_count}, 37'h0);
    chk("rst_immediateW", {ext_reqW, out_validW, src_valW, src_genW, dst_genW, ext_countW}, 26'h0);
    modelCg = 0;
    modelExt = 0;
    chkStats("rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release", {in_ready, in_readyW, out_valid, ext_req}, 4'b1100);
    runInstr("after_rst", 16'h4392, 0, 0);
    chkStats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
